// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and its fetch buffer.
package ifu_pkg;

    localparam int          XLEN_MAX     = 64;
    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    // Entry PCs are held at full width so one type serves every XLEN <= 64.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [31:0]         instr;
    } fb_entry_t;

endpackage

// File: rtl/ifu_fbuf_if.sv
// Instruction memory port: in-order request channel plus response channel.
interface ifu_fbuf_if #(
    parameter int XLEN = 64
);
    logic            ireq_valid;
    logic            ireq_ready;
    logic [XLEN-1:0] ireq_addr;
    logic            irsp_valid;
    logic [31:0]     irsp_instr;

    modport master (
        output ireq_valid, ireq_addr,
        input  ireq_ready, irsp_valid, irsp_instr
    );

    modport slave (
        input  ireq_valid, ireq_addr,
        output ireq_ready, irsp_valid, irsp_instr
    );
endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush; the head is read straight from storage (no output register).
module ifu_fifo #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // A pop frees the slot a simultaneous push needs, so full+pop+push is legal.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    // NOTE: rstn is sampled at the clock edge only, so it is tested inside the
    // clocked block and never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: storage is deliberately not reset; r_count alone says which slots are valid.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifu_fbuf.sv
// Instruction fetch unit: sequential PC generation, multi-outstanding memory port and
// decoupling fetch buffer. Optional counters: define IFU_FBUF_PERF_EN.
module ifu_fbuf
    import ifu_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter int              FB_DEPTH  = 4,
    parameter int              MAX_OUTST = 2
) (
    input  logic            clk,
    input  logic            rstn,
    ifu_fbuf_if.master      mem,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_pc,
    output logic            ifu_valid,
    input  logic            ifu_ready,
    output logic [XLEN-1:0] ifu_pc,
    output logic [31:0]     ifu_instr,
    output logic [XLEN-1:0] ifu_snxt_pc
`ifdef IFU_FBUF_PERF_EN
    ,
    output logic [63:0]     perf_fetched,
    output logic [63:0]     perf_dropped,
    output logic [63:0]     perf_stall
`endif
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int CW = $clog2(FB_DEPTH + 1);
    localparam int SW = ((OW > CW) ? OW : CW) + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_drop_cnt;
    logic [CW-1:0]   w_fb_count;
    logic [SW-1:0]   w_credit_sum;
    fb_entry_t       w_push_entry;
    fb_entry_t       w_head;
    logic            w_req_fire;
    logic            w_rsp_drop;
    logic            w_rsp_acc;
    logic            w_pop;

    // Credit: every request in flight owns a buffer slot, so an accepted response always fits.
    assign w_credit_sum   = SW'(r_outst) + SW'(w_fb_count);
    assign mem.ireq_valid = rstn && !jump_en && (w_credit_sum < SW'(FB_DEPTH))
                            && (r_outst < OW'(MAX_OUTST));
    assign mem.ireq_addr  = r_fetch_pc;
    assign w_req_fire     = mem.ireq_valid && mem.ireq_ready;

    // Responses to pre-redirect requests (including one arriving with the redirect) are stale.
    assign w_rsp_drop = mem.irsp_valid && (jump_en || (r_drop_cnt != '0));
    assign w_rsp_acc  = mem.irsp_valid && !w_rsp_drop;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_outst    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_outst <= r_outst + OW'(w_req_fire) - OW'(mem.irsp_valid);
            if (jump_en) begin
                r_fetch_pc <= jump_pc;
                r_rsp_pc   <= jump_pc;
                r_drop_cnt <= r_outst - OW'(mem.irsp_valid);
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_rsp_acc)  r_rsp_pc   <= r_rsp_pc + XLEN'(4);
                if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    assign w_push_entry.pc    = XLEN_MAX'(r_rsp_pc);
    assign w_push_entry.instr = mem.irsp_instr;

    ifu_fifo #(
        .WIDTH ($bits(fb_entry_t)),
        .DEPTH (FB_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_rsp_acc),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (jump_en),
        .o_head  (w_head),
        .o_count (w_fb_count)
    );

    assign ifu_valid   = rstn && (w_fb_count != '0);
    assign w_pop       = ifu_valid && ifu_ready;
    assign ifu_pc      = ifu_valid ? w_head.pc[XLEN-1:0] : '0;
    assign ifu_instr   = ifu_valid ? w_head.instr : NOP_INSTR;
    assign ifu_snxt_pc = ifu_valid ? w_head.pc[XLEN-1:0] + XLEN'(4) : '0;

`ifdef IFU_FBUF_PERF_EN
    logic [63:0] r_perf_fetched;
    logic [63:0] r_perf_dropped;
    logic [63:0] r_perf_stall;

    // Dropped counts stale responses plus whatever a redirect flushes from the buffer.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
            r_perf_stall   <= '0;
        end else begin
            r_perf_fetched <= r_perf_fetched + 64'(w_rsp_acc);
            r_perf_dropped <= r_perf_dropped + 64'(w_rsp_drop)
                              + (jump_en ? 64'(w_fb_count) : 64'd0);
            r_perf_stall   <= r_perf_stall + 64'(ifu_valid && !ifu_ready);
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_dropped = r_perf_dropped;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_ifu_fbuf.sv
// Randomised bench for ifu_fbuf: an epoch-tagged memory model and an expected-buffer queue
// predict every head; perf counters are checked when IFU_FBUF_PERF_EN is defined.
module tb_ifu_fbuf;

    localparam int          XLEN      = 64;
    localparam int          FB_DEPTH  = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [63:0] RST_PC    = 64'h8000_0000;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        jump_en = 1'b0;
    logic [63:0] jump_pc = '0;
    logic        ifu_ready = 1'b0;
    logic        ifu_valid;
    logic [63:0] ifu_pc;
    logic [31:0] ifu_instr;
    logic [63:0] ifu_snxt_pc;
`ifdef IFU_FBUF_PERF_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_dropped;
    logic [63:0] perf_stall;
`endif

    ifu_fbuf_if #(.XLEN(XLEN)) mif ();

    ifu_fbuf #(
        .XLEN      (XLEN),
        .RESET_PC  (RST_PC),
        .FB_DEPTH  (FB_DEPTH),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mem         (mif),
        .jump_en     (jump_en),
        .jump_pc     (jump_pc),
        .ifu_valid   (ifu_valid),
        .ifu_ready   (ifu_ready),
        .ifu_pc      (ifu_pc),
        .ifu_instr   (ifu_instr),
        .ifu_snxt_pc (ifu_snxt_pc)
`ifdef IFU_FBUF_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_dropped (perf_dropped),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Memory holds requests tagged with the redirect epoch they were issued in.
    typedef struct {
        logic [63:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        pending[$];
    logic [63:0] buf_q[$];
    int          epoch = 0;
    int          cyc = 0;
    int          last_due = 0;
    logic [63:0] exp_fetch = RST_PC;
    logic [63:0] exp_out_pc = RST_PC;
    int          lat_min = 1, lat_max = 1, rdy_pct = 100, dec_pct = 100;
    int          n_vec = 0, n_err = 0, n_fire = 0, n_pop = 0;
    logic [63:0] m_fetched = '0, m_dropped = '0, m_stall = '0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    // One clock: drive at the falling edge, sample before and after the rising edge.
    task automatic step(input bit jmp = 1'b0, input logic [63:0] jpc = 64'h0);
        bit          fire, pop, rsp, stall_c;
        logic [63:0] addr;
        req_t        e;
        int          due;
        jump_en        = jmp;
        jump_pc        = jpc;
        mif.ireq_ready = (int'($urandom_range(99)) < rdy_pct);
        ifu_ready      = (int'($urandom_range(99)) < dec_pct);
        rsp            = rstn && (pending.size() > 0) && (pending[0].due <= cyc + 1);
        mif.irsp_valid = rsp;
        mif.irsp_instr = rsp ? instr_of(pending[0].addr) : $urandom;
        #1;
        fire    = mif.ireq_valid && mif.ireq_ready;
        addr    = mif.ireq_addr;
        pop     = ifu_valid && ifu_ready;
        stall_c = ifu_valid && !ifu_ready;
        if (jmp || !rstn) begin
            n_vec++;
            if (mif.ireq_valid !== 1'b0) begin
                n_err++; $display("FAIL ireq_valid_blocked: got %b want 0 at cyc %0d", mif.ireq_valid, cyc);
            end
        end
        if (fire) begin
            n_vec++;
            if (addr !== exp_fetch) begin
                n_err++; $display("FAIL ireq_addr: got %h want %h at cyc %0d", addr, exp_fetch, cyc);
            end
        end
        if (pop) begin
            n_vec++;
            if (ifu_pc !== exp_out_pc) begin
                n_err++; $display("FAIL out_pc_seq: got %h want %h at cyc %0d", ifu_pc, exp_out_pc, cyc);
            end
        end
        @(posedge clk);
        cyc++;
        if (!rstn) begin
            pending.delete();
            buf_q.delete();
            epoch++;
            last_due   = 0;
            exp_fetch  = RST_PC;
            exp_out_pc = RST_PC;
            m_fetched  = '0;
            m_dropped  = '0;
            m_stall    = '0;
        end else begin
            if (pop && !jmp && buf_q.size() > 0) begin
                void'(buf_q.pop_front());
                exp_out_pc += 64'd4;
                n_pop++;
            end
            if (rsp) begin
                e = pending.pop_front();
                if (e.epoch == epoch && !jmp) begin
                    buf_q.push_back(e.addr);
                    m_fetched += 64'd1;
                end else begin
                    m_dropped += 64'd1;
                end
            end
            if (fire) begin
                due = cyc + int'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                e.addr = addr; e.epoch = epoch; e.due = due;
                pending.push_back(e);
                exp_fetch += 64'd4;
                n_fire++;
            end
            if (jmp) begin
                m_dropped += 64'(buf_q.size());
                buf_q.delete();
                epoch++;
                exp_fetch  = jpc;
                exp_out_pc = jpc;
            end
            if (stall_c) m_stall += 64'd1;
        end
        @(negedge clk);
        n_vec++;
        if (ifu_valid !== (buf_q.size() != 0)) begin
            n_err++; $display("FAIL ifu_valid: got %b want %b at cyc %0d", ifu_valid, buf_q.size() != 0, cyc);
        end
        n_vec++;
        if (buf_q.size() != 0) begin
            if (ifu_pc !== buf_q[0] || ifu_instr !== instr_of(buf_q[0]) || ifu_snxt_pc !== buf_q[0] + 64'd4) begin
                n_err++; $display("FAIL head: got pc %h instr %h snxt %h want pc %h instr %h at cyc %0d",
                                  ifu_pc, ifu_instr, ifu_snxt_pc, buf_q[0], instr_of(buf_q[0]), cyc);
            end
        end else if (ifu_instr !== NOP || ifu_pc !== '0 || ifu_snxt_pc !== '0) begin
            n_err++; $display("FAIL idle_outputs: got pc %h instr %h snxt %h want 0/%h/0 at cyc %0d",
                              ifu_pc, ifu_instr, ifu_snxt_pc, NOP, cyc);
        end
        n_vec++;
        if (pending.size() > MAX_OUTST || pending.size() + buf_q.size() > FB_DEPTH) begin
            n_err++; $display("FAIL credit: got outst %0d buffered %0d want outst<=%0d sum<=%0d",
                              pending.size(), buf_q.size(), MAX_OUTST, FB_DEPTH);
        end
`ifdef IFU_FBUF_PERF_EN
        n_vec++;
        if (perf_fetched !== m_fetched || perf_dropped !== m_dropped || perf_stall !== m_stall) begin
            n_err++; $display("FAIL perf: got %0d/%0d/%0d want %0d/%0d/%0d at cyc %0d",
                              perf_fetched, perf_dropped, perf_stall, m_fetched, m_dropped, m_stall, cyc);
        end
`endif
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        n_vec++;
        if (mif.ireq_addr !== RST_PC) begin
            n_err++; $display("FAIL reset_fetch_pc: got %h want %h", mif.ireq_addr, RST_PC);
        end
        n_vec++;
        if (ifu_valid !== 1'b0 || ifu_instr !== NOP || ifu_pc !== '0) begin
            n_err++; $display("FAIL reset_outputs: got v %b instr %h pc %h", ifu_valid, ifu_instr, ifu_pc);
        end
        rstn = 1'b1;
    endtask

    task automatic test_first_fetch();
        int f0, p0;
        lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100;
        f0 = n_fire;
        step();
        n_vec++;
        if (n_fire - f0 != 1 || ifu_valid !== 1'b0) begin
            n_err++; $display("FAIL first_request: got %0d requests valid %b want 1 and 0", n_fire - f0, ifu_valid);
        end
        step();
        n_vec++;
        if (ifu_valid !== 1'b1 || ifu_pc !== RST_PC) begin
            n_err++; $display("FAIL first_head: got v %b pc %h want 1 %h", ifu_valid, ifu_pc, RST_PC);
        end
        p0 = n_pop;
        repeat (20) step();
        n_vec++;
        if (n_pop - p0 != 20) begin
            n_err++; $display("FAIL throughput: got %0d pops want 20", n_pop - p0);
        end
    endtask

    task automatic test_stall();
        int p0, f0;
        lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 0;
        repeat (10) step();
        n_vec++;
        if (buf_q.size() != FB_DEPTH || mif.ireq_valid !== 1'b0 || pending.size() != 0) begin
            n_err++; $display("FAIL stall_fill: got buffered %0d ireq_valid %b outst %0d want %0d 0 0",
                              buf_q.size(), mif.ireq_valid, pending.size(), FB_DEPTH);
        end
        dec_pct = 100;
        p0 = n_pop;
        repeat (4) step();
        n_vec++;
        if (n_pop - p0 != 4) begin
            n_err++; $display("FAIL stall_release: got %0d pops want 4", n_pop - p0);
        end
        f0 = n_fire;
        repeat (6) step();
        n_vec++;
        if (n_fire == f0) begin
            n_err++; $display("FAIL fetch_resume: got 0 requests want >0");
        end
    endtask

    task automatic test_jump_flush();
        bit found = 1'b0;
        logic [63:0] d0 = '0;
        lat_min = 3; lat_max = 3; rdy_pct = 100; dec_pct = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (pending.size() == 2 && buf_q.size() == 2) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++; $display("FAIL jump_setup: got outst %0d buffered %0d want 2 2", pending.size(), buf_q.size());
        end
`ifdef IFU_FBUF_PERF_EN
        d0 = perf_dropped;
`endif
        step(1'b1, 64'h8000_1000);
        n_vec++;
        if (mif.ireq_addr !== 64'h8000_1000 || ifu_valid !== 1'b0) begin
            n_err++; $display("FAIL jump_addr: got addr %h valid %b want 80001000 0", mif.ireq_addr, ifu_valid);
        end
        dec_pct = 100;
        for (int i = 0; i < 20 && ifu_valid !== 1'b1; i++) step();
        n_vec++;
        if (ifu_valid !== 1'b1 || ifu_pc !== 64'h8000_1000) begin
            n_err++; $display("FAIL jump_first_head: got v %b pc %h want 1 80001000", ifu_valid, ifu_pc);
        end
`ifdef IFU_FBUF_PERF_EN
        n_vec++;
        if (perf_dropped - d0 !== 64'd4) begin
            n_err++; $display("FAIL jump_perf_dropped: got %0d want 4", perf_dropped - d0);
        end
`else
        d0 = d0 + 64'd1;
`endif
    endtask

    task automatic test_jump_same_cycle();
        bit found = 1'b0;
        int f0;
        lat_min = 2; lat_max = 2; rdy_pct = 100; dec_pct = 100;
        for (int i = 0; i < 20 && !found; i++) begin
            if (pending.size() > 0 && pending[0].due == cyc + 1) found = 1'b1;
            else step();
        end
        n_vec++;
        if (!found) begin
            n_err++; $display("FAIL same_cycle_setup: got no response due want one");
        end
        step(1'b1, 64'h0000_0000_0000_2000);
        n_vec++;
        if (mif.ireq_addr !== 64'h2000) begin
            n_err++; $display("FAIL same_cycle_addr: got %h want 2000", mif.ireq_addr);
        end
        f0 = n_fire;
        for (int i = 0; i < 10 && n_fire == f0; i++) step();
        n_vec++;
        if (n_fire == f0) begin
            n_err++; $display("FAIL same_cycle_refetch: got 0 requests want >0");
        end
        repeat (10) step();
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 3; rdy_pct = 60; dec_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 2) step(1'b1, {$urandom, $urandom} & ~64'h3);
            else step();
        end
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        rdy_pct = 90; dec_pct = 90;
        repeat (40) step();
    endtask

    initial begin
        mif.ireq_ready = 1'b0;
        mif.irsp_valid = 1'b0;
        mif.irsp_instr = '0;
        test_reset();
        test_first_fetch();
        test_stall();
        test_reset();
        test_jump_flush();
        test_jump_same_cycle();
        test_random();
        test_reset();
        test_first_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
